// File: rtl/skew_feeder_if.sv
// Handshake/bus bundle for skew_feeder: tile load port, stream control and skewed output lanes.
// master = software/array side, slave = the feeder itself.
interface skew_feeder_if #(
    parameter int BITS = 8,
    parameter int DIM  = 8
);
    localparam int ROWBITS = (DIM > 1) ? $clog2(DIM) : 1;

    logic                      wr_en;
    logic [ROWBITS-1:0]        wr_row;
    logic signed [BITS-1:0]    din [DIM];
    logic                      wr_commit;
    logic                      load_ready;
    logic                      start;
    logic                      en;
    logic                      busy;
    logic signed [BITS-1:0]    dout [DIM];
    logic                      dout_valid;
    logic                      done;

    modport master (
        output wr_en, wr_row, din, wr_commit, start, en,
        input  load_ready, busy, dout, dout_valid, done
    );

    modport slave (
        input  wr_en, wr_row, din, wr_commit, start, en,
        output load_ready, busy, dout, dout_valid, done
    );
endinterface

// File: rtl/skew_feeder.sv
// Double-buffered DIM x DIM operand stager that streams committed tiles into a systolic array with diagonal skew.
// Optional macro SKEW_FEEDER_AUTOSTART_EN: chain straight into the other bank when it is already full.
//
// state  | meaning
// IDLE   | waiting for start with the stream bank full
// STREAM | emitting beats t = 0 .. 2*DIM-2 on each en cycle
module skew_feeder #(
    parameter int BITS      = 8,
    parameter int DIM       = 8,
    parameter int TRANSPOSE = 0
) (
    input  logic            clk,
    input  logic            rst,
    skew_feeder_if.slave    bus
);
    localparam int ROWBITS = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int TBITS   = $clog2(2 * DIM);
    localparam int LAST    = 2 * DIM - 2;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q;
    logic signed [BITS-1:0]  mem_q [2][DIM][DIM];
    logic [1:0]              full_q;
    logic                    lp_q;
    logic                    sp_q;
    logic [TBITS-1:0]        t_q;
    logic signed [BITS-1:0]  dout_q [DIM];
    logic                    dout_valid_q;
    logic                    done_q;

    logic                    load_ready;
    logic                    last_beat;
    logic                    chain_next;
    logic signed [BITS-1:0]  beat_d [DIM];

    assign load_ready = ~full_q[lp_q];
    assign last_beat  = (t_q == TBITS'(LAST));

`ifdef SKEW_FEEDER_AUTOSTART_EN
    assign chain_next = full_q[~sp_q];
`else
    assign chain_next = 1'b0;
`endif

    // Element for lane k at beat t: diagonal index t-k selects column (A style) or row (B style).
    always_comb begin : beat_sel
        int diff;
        diff = 0;
        for (int k = 0; k < DIM; k++) begin
            beat_d[k] = '0;
            diff = int'(t_q) - k;
            if (diff >= 0 && diff < DIM) begin
                if (TRANSPOSE != 0) begin
                    beat_d[k] = mem_q[sp_q][ROWBITS'(diff)][ROWBITS'(k)];
                end else begin
                    beat_d[k] = mem_q[sp_q][ROWBITS'(k)][ROWBITS'(diff)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
            full_q       <= '0;
            lp_q         <= 1'b0;
            sp_q         <= 1'b0;
            state_q      <= IDLE;
            t_q          <= '0;
            for (int k = 0; k < DIM; k++) begin
                dout_q[k] <= '0;
            end
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (bus.wr_en && load_ready) begin
                for (int c = 0; c < DIM; c++) begin
                    mem_q[lp_q][bus.wr_row][c] <= bus.din[c];
                end
            end

            for (int k = 0; k < DIM; k++) begin
                dout_q[k] <= '0;
            end
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start && full_q[sp_q]) begin
                        state_q <= STREAM;
                        t_q     <= '0;
                    end
                end
                STREAM: begin
                    if (bus.en) begin
                        for (int k = 0; k < DIM; k++) begin
                            dout_q[k] <= beat_d[k];
                        end
                        dout_valid_q <= 1'b1;
                        if (last_beat) begin
                            // Free the streamed bank so a later load sees all-zero rows.
                            for (int r = 0; r < DIM; r++) begin
                                for (int c = 0; c < DIM; c++) begin
                                    mem_q[sp_q][r][c] <= '0;
                                end
                            end
                            done_q         <= 1'b1;
                            full_q[sp_q]   <= 1'b0;
                            sp_q           <= ~sp_q;
                            t_q            <= '0;
                            state_q        <= chain_next ? STREAM : IDLE;
                        end else begin
                            t_q <= t_q + TBITS'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The load bank is never the streaming bank while it is EMPTY, so this cannot collide with the free above.
            if (bus.wr_commit && load_ready) begin
                full_q[lp_q] <= 1'b1;
                lp_q         <= ~lp_q;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            bus.dout[k] = dout_q[k];
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q == STREAM);
    assign bus.load_ready = load_ready;
endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: A-style and B-style instances share stimulus and are checked every cycle
// against a tile-FIFO model, plus hand-computed beat values.
module tb_skew_feeder;
    localparam int BITS = 8;
    localparam int DIM  = 8;
    localparam int NBEAT = 2 * DIM - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skew_feeder_if #(.BITS(BITS), .DIM(DIM)) bus0 ();
    skew_feeder_if #(.BITS(BITS), .DIM(DIM)) bus1 ();

    assign bus1.wr_en     = bus0.wr_en;
    assign bus1.wr_row    = bus0.wr_row;
    assign bus1.din       = bus0.din;
    assign bus1.wr_commit = bus0.wr_commit;
    assign bus1.start     = bus0.start;
    assign bus1.en        = bus0.en;

    skew_feeder #(.BITS(BITS), .DIM(DIM), .TRANSPOSE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    skew_feeder #(.BITS(BITS), .DIM(DIM), .TRANSPOSE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    int cyc = 0;

    // Model: FIFO of committed tiles (head is the one streaming or next to stream) plus the tile being loaded.
    int  tiles [2][DIM][DIM];
    int  head = 0, cnt = 0;
    int  cur [DIM][DIM];
    bit  streaming = 0;
    int  mt = 0;
    int  exp0 [DIM];
    int  exp1 [DIM];
    bit  ev = 0, ed = 0;

    int  log0 [64][DIM];
    int  log1 [64][DIM];
    bit  dlog [64];
    int  bcyc [64];
    int  bcnt = 0;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int elem(input int tr, input int k, input int t);
        int j;
        j = t - k;
        if (j < 0 || j >= DIM) return 0;
        return (tr != 0) ? tiles[head][j][k] : tiles[head][k][j];
    endfunction

    always @(posedge clk) begin
        int pre;
        bit lr;
        if (rst) begin
            head = 0; cnt = 0; streaming = 0; mt = 0; ev = 0; ed = 0;
            for (int r = 0; r < DIM; r++) begin
                exp0[r] = 0; exp1[r] = 0;
                for (int c = 0; c < DIM; c++) cur[r][c] = 0;
            end
        end else begin
            pre = cnt;
            lr  = (cnt < 2);
            if (bus0.wr_en && lr)
                for (int c = 0; c < DIM; c++) cur[bus0.wr_row][c] = int'(bus0.din[c]);
            ev = 0; ed = 0;
            for (int k = 0; k < DIM; k++) begin exp0[k] = 0; exp1[k] = 0; end
            if (streaming) begin
                if (bus0.en) begin
                    ev = 1;
                    for (int k = 0; k < DIM; k++) begin
                        exp0[k] = elem(0, k, mt);
                        exp1[k] = elem(1, k, mt);
                    end
                    if (mt == NBEAT - 1) begin
                        ed = 1;
                        head = (head + 1) % 2;
                        cnt--;
                        mt = 0;
                        streaming = 0;
`ifdef SKEW_FEEDER_AUTOSTART_EN
                        if (pre == 2) streaming = 1;
`endif
                    end else begin
                        mt++;
                    end
                end
            end else if (bus0.start && pre >= 1) begin
                streaming = 1;
                mt = 0;
            end
            if (bus0.wr_commit && lr) begin
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++) begin
                        tiles[(head + cnt) % 2][r][c] = cur[r][c];
                        cur[r][c] = 0;
                    end
                cnt++;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("busy0", int'(bus0.busy), int'(streaming));
            chk("busy1", int'(bus1.busy), int'(streaming));
            chk("load_ready0", int'(bus0.load_ready), int'(cnt < 2));
            chk("load_ready1", int'(bus1.load_ready), int'(cnt < 2));
            chk("valid0", int'(bus0.dout_valid), int'(ev));
            chk("valid1", int'(bus1.dout_valid), int'(ev));
            chk("done0", int'(bus0.done), int'(ed));
            chk("done1", int'(bus1.done), int'(ed));
            for (int k = 0; k < DIM; k++) begin
                chk($sformatf("dout0[%0d]", k), int'(bus0.dout[k]), exp0[k]);
                chk($sformatf("dout1[%0d]", k), int'(bus1.dout[k]), exp1[k]);
            end
            if (bus0.dout_valid && bcnt < 64) begin
                for (int k = 0; k < DIM; k++) begin
                    log0[bcnt][k] = int'(bus0.dout[k]);
                    log1[bcnt][k] = int'(bus1.dout[k]);
                end
                dlog[bcnt] = bus0.done;
                bcyc[bcnt] = cyc;
                bcnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_tile(input int kind);
        for (int r = 0; r < DIM; r++) begin
            bus0.wr_en     = 1'b1;
            bus0.wr_row    = 3'(r);
            bus0.wr_commit = (r == DIM - 1);
            for (int c = 0; c < DIM; c++)
                bus0.din[c] = (kind == 0) ? 8'(r * 8 + c + 1) : 8'(kind);
            tick();
        end
        bus0.wr_en     = 1'b0;
        bus0.wr_commit = 1'b0;
    endtask

    task automatic pulse_start();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int i;
        i = 0;
        while (bcnt < n && i < budget) begin
            tick();
            i++;
        end
        chk("beat_wait", bcnt, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst = 1'b1;
        bus0.wr_en = 0; bus0.wr_row = 0; bus0.wr_commit = 0; bus0.start = 0; bus0.en = 1;
        for (int c = 0; c < DIM; c++) bus0.din[c] = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("reset_load_ready", int'(bus0.load_ready), 1);
        chk("reset_valid", int'(bus0.dout_valid), 0);
        rst = 1'b0;

        // start with nothing committed is ignored
        bus0.start = 1'b1;
        repeat (20) tick();
        bus0.start = 1'b0;
        chk("empty_busy", int'(bus0.busy), 0);
        chk("empty_load_ready", int'(bus0.load_ready), 1);
        chk("empty_beats", bcnt, 0);

        // counting tile, both orientations
        load_tile(0);
        bcnt = 0;
        pulse_start();
        chk("latency_none_yet", bcnt, 0);
        tick();
        chk("latency_first", bcnt, 1);
        wait_beats(NBEAT, 40);
        repeat (3) tick();
        chk("a_beats", bcnt, NBEAT);
        chk("a_b3_l3", log0[3][3], 25);
        chk("a_b3_l4", log0[3][4], 0);
        chk("a_b10_l7", log0[10][7], 60);
        chk("a_b14_l7", log0[14][7], 64);
        chk("a_done14", int'(dlog[14]), 1);
        chk("a_done13", int'(dlog[13]), 0);
        chk("b_b3_l3", log1[3][3], 4);
        chk("b_b3_l0", log1[3][0], 25);
        chk("b_b14_l7", log1[14][7], 64);

        // two tiles queued, ignored write/commit while both banks full
        load_tile(1);
        load_tile(2);
        chk("both_full_lr", int'(bus0.load_ready), 0);
        bus0.wr_en = 1; bus0.wr_row = 3; bus0.wr_commit = 1;
        for (int c = 0; c < DIM; c++) bus0.din[c] = 7;
        tick();
        bus0.wr_en = 0; bus0.wr_commit = 0;
        bcnt = 0;
        pulse_start();
        wait_beats(NBEAT, 40);
        tick();
        chk("x_val", log0[7][0], 1);
        chk("x_freed_lr", int'(bus0.load_ready), 1);
        pulse_start();
        wait_beats(2 * NBEAT, 60);
        tick();
        chk("y_val_a", log0[NBEAT + 7][3], 2);
        chk("y_val_b", log1[NBEAT + 10][6], 2);

        // stall for three cycles after five beats
        load_tile(0);
        bcnt = 0;
        pulse_start();
        wait_beats(5, 40);
        bus0.en = 0;
        repeat (3) tick();
        chk("stall_hold", bcnt, 5);
        bus0.en = 1;
        wait_beats(NBEAT, 40);
        tick();
        chk("stall_total", bcnt, NBEAT);
        chk("stall_resume_a", log0[5][5], 41);
        chk("stall_resume_b", log1[5][2], 27);

        // reset in the middle of a stream
        load_tile(1);
        bcnt = 0;
        pulse_start();
        wait_beats(7, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        ndone = 0;
        for (int i = 0; i < bcnt; i++) ndone += int'(dlog[i]);
        chk("rst_beats", bcnt, 7);
        chk("rst_no_done", ndone, 0);
        chk("rst_load_ready", int'(bus0.load_ready), 1);
        chk("rst_valid", int'(bus0.dout_valid), 0);

        // two tiles, single start
        load_tile(0);
        load_tile(1);
        bcnt = 0;
        pulse_start();
`ifdef SKEW_FEEDER_AUTOSTART_EN
        wait_beats(2 * NBEAT, 80);
        tick();
        chk("auto_beats", bcnt, 2 * NBEAT);
        chk("auto_contig", bcyc[2 * NBEAT - 1] - bcyc[0], 2 * NBEAT - 1);
        chk("auto_done1", int'(dlog[NBEAT - 1]), 1);
        chk("auto_done2", int'(dlog[2 * NBEAT - 1]), 1);
        chk("auto_done_gap", bcyc[2 * NBEAT - 1] - bcyc[NBEAT - 1], NBEAT);
        chk("auto_tile2", log0[NBEAT + 3][3], 1);
`else
        wait_beats(NBEAT, 40);
        repeat (5) tick();
        chk("noauto_beats", bcnt, NBEAT);
        chk("noauto_idle", int'(bus0.busy), 0);
        pulse_start();
        wait_beats(2 * NBEAT, 60);
        tick();
        chk("noauto_tile2", log0[NBEAT + 3][3], 1);
`endif

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            bus0.wr_en     = ($urandom_range(0, 1) == 1);
            bus0.wr_row    = 3'($urandom_range(0, DIM - 1));
            for (int c = 0; c < DIM; c++) bus0.din[c] = 8'($urandom_range(0, 255));
            bus0.wr_commit = ($urandom_range(0, 11) == 0);
            bus0.start     = ($urandom_range(0, 5) == 0);
            bus0.en        = ($urandom_range(0, 9) < 8);
            rst            = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; bus0.wr_en = 0; bus0.wr_commit = 0; bus0.start = 0; bus0.en = 1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Parametrised, double-buffered operand staging memory for the DIM x DIM systolic array. Generalises the separate A and B feeders into one block.
- Software-side logic writes a full DIM x DIM tile row-by-row into a load bank, then commits it.
- The block streams committed tiles into the array with diagonal skew, either row-major (A operand) or transposed (B operand), while the other bank is being loaded.

Parameters:
BITS, 8, element width in bits (signed)
DIM, 8, array dimension; tile is DIM x DIM
TRANSPOSE, 0, 0 = lane k carries row k (A style); 1 = lane k carries column k (B style)
ROWBITS, $clog2(DIM), derived localparam, row index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write din into row wr_row of the load bank
wr_row  in  ROWBITS  row address
din  in  DIM x BITS (unpacked, signed)  row data, din[c] = M[wr_row][c]
wr_commit  in  1  mark the load bank full
load_ready  out  1  load bank is EMPTY and accepts writes/commit
start  in  1  request streaming of the oldest full bank
en  in  1  stream advance enable (stall when low)
busy  out  1  FSM in STREAM
dout  out  DIM x BITS (unpacked, signed)  skewed output lanes to the array
dout_valid  out  1  dout carries a stream beat
done  out  1  one-cycle pulse after the last beat

Behaviour:
- One clock, synchronous active-high reset.
- Two banks, each with state EMPTY or FULL. Pointers lp (load bank) and sp (stream bank).
- load_ready = (bank[lp] == EMPTY).
- Reset values:
  - All bank storage zeroed; both banks EMPTY; lp = sp = 0; FSM IDLE; beat counter t = 0.
  - Outputs: dout all 0, dout_valid 0, done 0, busy 0, load_ready 1.
- Writes:
  - wr_en with load_ready = 1 writes din into bank[lp] row wr_row at the clock edge.
  - wr_en with load_ready = 0 is ignored.
- Commit:
  - wr_commit with load_ready = 1 sets bank[lp] to FULL and toggles lp.
  - wr_commit with load_ready = 0 is ignored.
  - wr_en and wr_commit in the same cycle: the row is written first, then the bank is committed, so the row is included.
  - Rows never written since the bank was last freed read as 0.
- FSM IDLE -> STREAM:
  - Transition on start when bank[sp] == FULL. start is ignored in STREAM or when bank[sp] is EMPTY.
  - t is cleared to 0 on entry.
- STREAM:
  - Each cycle with en = 1, registered outputs update: dout_valid <= 1, and dout[k] <= E(k,t) for k = 0..DIM-1.
    - TRANSPOSE = 0: E(k,t) = M[k][t-k].
    - TRANSPOSE = 1: E(k,t) = M[t-k][k].
    - E = 0 when t-k is outside 0..DIM-1.
    - Then t increments.
  - Stream length is 2*DIM-1 beats (t = 0..2*DIM-2).
  - Latency: start accepted at edge n; the first beat is visible after edge n+1.
- en = 0 in STREAM: t holds, dout_valid = 0, dout = 0.
- Outside beats, dout = 0 and dout_valid = 0.
- Last beat (t = 2*DIM-2, en = 1):
  - done pulses 1 in the same cycle dout_valid shows the last beat.
  - bank[sp] is zeroed and set EMPTY; sp toggles; FSM returns to IDLE.
  - A start in that same cycle is ignored.
- Both banks FULL: load_ready = 0 until the streamed bank is freed. Tiles stream in commit order (0, 1, 0, 1, ...).
- A commit while the other bank streams is legal and independent.
- rst mid-stream: immediate return to reset state. No done pulse; all data discarded.

Optional Feature:
SKEW_FEEDER_AUTOSTART_EN
- Defined: at the last beat, if the other bank is FULL, the FSM stays in STREAM with t = 0 on sp^1. That tile's first beat follows on the next en cycle with no bubble, and no start is needed. Loading from IDLE still requires start.
- Undefined: the FSM always returns to IDLE after done; each tile needs its own start.

Test Plan:
- Reset, then start with both banks EMPTY -> busy 0, dout_valid 0, dout all 0, load_ready 1 for 20 cycles.
- TRANSPOSE = 0: load M[r][c] = r*8+c+1, commit, start, en = 1 -> 15 valid beats; beat 3: dout[3] = 25, dout[4] = 0; beat 10: dout[7] = 60; beat 14: dout[7] = 64 with done = 1.
- TRANSPOSE = 1, same tile -> beat 3: dout[3] = 4, dout[0] = 25; beat 14: dout[7] = 64.
- Commit tile X (all 1), commit tile Y (all 2) -> load_ready = 0; start -> stream X; after done, load_ready = 1; start -> stream Y with values 2. Writes issued while load_ready = 0 leave Y unchanged.
- Mid-stream en = 0 for 3 cycles at beat 5 -> dout_valid 0 for 3 cycles; resumes at beat 5 with identical values; total 15 beats. rst at beat 7 -> no done; outputs 0; load_ready 1.
- With SKEW_FEEDER_AUTOSTART_EN, two tiles committed and a single start -> 30 consecutive valid beats and two done pulses, 15 cycles apart.
